// File: rtl/machine_csr_unit_pkg.sv
// Shared CSR addresses, field indices, trap codes and the read-modify-write helper
// for the machine-mode CSR unit.
package machine_csr_unit_pkg;

   typedef enum logic [1:0] {
      CSROP_READ = 2'b00,
      CSROP_RW   = 2'b01,
      CSROP_RS   = 2'b10,
      CSROP_RC   = 2'b11
   } csrOp_e;

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MISA     = 12'h301;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
   localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
   localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
   localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
   localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIP_MSIP     = 3;
   localparam int MIP_MTIP     = 7;
   localparam int MIP_MEIP     = 11;

   localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
   localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
   localparam logic [31:0] MIE_MASK      = 32'h0000_0888;

   localparam logic [4:0] IRQ_MSI            = 5'd3;
   localparam logic [4:0] IRQ_MTI            = 5'd7;
   localparam logic [4:0] IRQ_MEI            = 5'd11;
   localparam logic [4:0] EXC_INSTR_MISALIGN = 5'd0;
   localparam logic [4:0] EXC_ILLEGAL_INSTR  = 5'd2;
   localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
   localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
   localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
   localparam logic [4:0] EXC_ECALL_M        = 5'd11;

   function automatic logic [31:0] csr_apply(input csrOp_e op, input logic [31:0] old_val,
                                             input logic [31:0] wdata);
      case (op)
         CSROP_RW: csr_apply = wdata;
         CSROP_RS: csr_apply = old_val | wdata;
         CSROP_RC: csr_apply = old_val & ~wdata;
         default:  csr_apply = old_val;
      endcase
   endfunction

endpackage

// File: rtl/machine_csr_unit_csr_counter.sv
// Free-running wrapping counter with independent 32-bit half writes; a write to
// either half replaces that half and suppresses the increment for that cycle.
module csr_counter
   import machine_csr_unit_pkg::*;
#(
   parameter int COUNTER_WIDTH = 64,
   parameter int INC_WIDTH     = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [INC_WIDTH-1:0]     i_inc,
   input  logic                     i_wr_lo,
   input  logic                     i_wr_hi,
   input  logic [31:0]              i_wdata,
   output logic [COUNTER_WIDTH-1:0] o_count
);

   logic [COUNTER_WIDTH-1:0] r_count;

   generate
      if (COUNTER_WIDTH > 32) begin : g_wide
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_count <= '0;
            end else if (i_wr_lo || i_wr_hi) begin
               if (i_wr_lo) r_count[31:0] <= i_wdata;
               if (i_wr_hi) r_count[COUNTER_WIDTH-1:32] <= i_wdata[COUNTER_WIDTH-33:0];
            end else begin
               r_count <= r_count + COUNTER_WIDTH'(i_inc);
            end
         end
      end else begin : g_narrow
         // No high half exists; a stray high write only freezes the count.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_count <= '0;
            end else if (i_wr_lo || i_wr_hi) begin
               if (i_wr_lo) r_count <= i_wdata[COUNTER_WIDTH-1:0];
            end else begin
               r_count <= r_count + COUNTER_WIDTH'(i_inc);
            end
         end
      end
   endgenerate

   assign o_count = r_count;

endmodule

// File: rtl/machine_csr_unit.sv
// Machine-mode CSR file: address decode, atomic RW/RS/RC, trap/mret stacking,
// vectored mtvec, cycle/instret counters and interrupt pending/cause.
module machine_csr_unit
   import machine_csr_unit_pkg::*;
#(
   parameter int COUNTER_WIDTH = 64,
   parameter int RETIRE_WIDTH  = 2,
   parameter bit VECTORED_EN   = 1'b1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              csrValid,
   input  logic [1:0]                        csrOp,
   input  logic [11:0]                       csrAddr,
   input  logic [31:0]                       csrWriteData,
   output logic [31:0]                       csrReadData,
   output logic                              csrIllegal,
   input  logic [$clog2(RETIRE_WIDTH+1)-1:0] retireCount,
   input  logic                              trapValid,
   input  logic                              trapIsInterrupt,
   input  logic [4:0]                        trapCause,
   input  logic [31:0]                       trapPC,
   input  logic [31:0]                       trapValue,
   input  logic                              mretValid,
   output logic [31:0]                       trapVector,
   output logic [31:0]                       mepcOut,
   input  logic                              softwareIrq,
   input  logic                              timerIrq,
   input  logic                              externalIrq,
   output logic                              irqPending,
   output logic [4:0]                        irqCause
);

   localparam int RC_W = $clog2(RETIRE_WIDTH+1);

   logic        r_mstatus_mie, r_mstatus_mpie;
   logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;

   logic [COUNTER_WIDTH-1:0] w_mcycle, w_minstret;
   logic [63:0] w_cycle64, w_instret64;
   logic [31:0] w_mstatus, w_mip, w_irq_en, w_old, w_new;
   logic        w_impl, w_hi_addr, w_illegal, w_wr;

   assign w_cycle64   = 64'(w_mcycle);
   assign w_instret64 = 64'(w_minstret);

   always_comb begin
      w_mstatus = MSTATUS_MPP_M;
      w_mstatus[MSTATUS_MIE]  = r_mstatus_mie;
      w_mstatus[MSTATUS_MPIE] = r_mstatus_mpie;
      w_mip = '0;
      w_mip[MIP_MSIP] = softwareIrq;
      w_mip[MIP_MTIP] = timerIrq;
      w_mip[MIP_MEIP] = externalIrq;
   end

   always_comb begin
      w_impl = 1'b1;
      w_old  = '0;
      case (csrAddr)
         ADDR_MSTATUS:                  w_old = w_mstatus;
         ADDR_MISA:                     w_old = MISA_VALUE;
         ADDR_MIE:                      w_old = r_mie;
         ADDR_MTVEC:                    w_old = r_mtvec;
         ADDR_MSCRATCH:                 w_old = r_mscratch;
         ADDR_MEPC:                     w_old = r_mepc;
         ADDR_MCAUSE:                   w_old = r_mcause;
         ADDR_MTVAL:                    w_old = r_mtval;
         ADDR_MIP:                      w_old = w_mip;
         ADDR_MCYCLE,   ADDR_CYCLE:     w_old = w_cycle64[31:0];
         ADDR_MCYCLEH,  ADDR_CYCLEH:    w_old = w_cycle64[63:32];
         ADDR_MINSTRET, ADDR_INSTRET:   w_old = w_instret64[31:0];
         ADDR_MINSTRETH, ADDR_INSTRETH: w_old = w_instret64[63:32];
         ADDR_MHARTID:                  w_old = '0;
         default:                       w_impl = 1'b0;
      endcase
   end

   assign w_hi_addr = (csrAddr == ADDR_MCYCLEH) || (csrAddr == ADDR_MINSTRETH) ||
                      (csrAddr == ADDR_CYCLEH)  || (csrAddr == ADDR_INSTRETH);

   assign w_illegal = csrValid && (!w_impl ||
                      ((csrOp != CSROP_READ) && (csrAddr[11:10] == 2'b11)) ||
                      (w_hi_addr && (COUNTER_WIDTH == 32)));

   assign csrIllegal  = w_illegal;
   assign csrReadData = w_illegal ? 32'h0 : w_old;
   assign w_new       = csr_apply(csrOp_e'(csrOp), w_old, csrWriteData);

   // Trap and mret own the CSR state this cycle, so any coinciding write is dropped.
   assign w_wr = csrValid && !w_illegal && (csrOp != CSROP_READ) && !trapValid && !mretValid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= '0;
         r_mtvec        <= '0;
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
         r_mtval        <= '0;
      end else if (trapValid) begin
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
         r_mepc         <= {trapPC[31:2], 2'b00};
         r_mcause       <= {trapIsInterrupt, 26'b0, trapCause};
         r_mtval        <= trapValue;
      end else if (mretValid) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else if (w_wr) begin
         case (csrAddr)
            ADDR_MSTATUS: begin
               r_mstatus_mie  <= w_new[MSTATUS_MIE];
               r_mstatus_mpie <= w_new[MSTATUS_MPIE];
            end
            ADDR_MIE:      r_mie      <= w_new & MIE_MASK;
            ADDR_MTVEC:    r_mtvec    <= {w_new[31:2], 1'b0, w_new[0] & VECTORED_EN};
            ADDR_MSCRATCH: r_mscratch <= w_new;
            ADDR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
            ADDR_MCAUSE:   r_mcause   <= w_new;
            ADDR_MTVAL:    r_mtval    <= w_new;
            default: ;
         endcase
      end
   end

   csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_mcycle (
      .clock   (clock),
      .reset   (reset),
      .i_inc   (1'b1),
      .i_wr_lo (w_wr && (csrAddr == ADDR_MCYCLE)),
      .i_wr_hi (w_wr && (csrAddr == ADDR_MCYCLEH)),
      .i_wdata (w_new),
      .o_count (w_mcycle)
   );

   csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH), .INC_WIDTH(RC_W)) u_minstret (
      .clock   (clock),
      .reset   (reset),
      .i_inc   (retireCount),
      .i_wr_lo (w_wr && (csrAddr == ADDR_MINSTRET)),
      .i_wr_hi (w_wr && (csrAddr == ADDR_MINSTRETH)),
      .i_wdata (w_new),
      .o_count (w_minstret)
   );

   assign w_irq_en   = w_mip & r_mie;
   assign irqPending = r_mstatus_mie && (|w_irq_en);

   always_comb begin
      irqCause = 5'd0;
      if (w_irq_en[MIP_MEIP])      irqCause = IRQ_MEI;
      else if (w_irq_en[MIP_MSIP]) irqCause = IRQ_MSI;
      else if (w_irq_en[MIP_MTIP]) irqCause = IRQ_MTI;
   end

   assign trapVector = {r_mtvec[31:2], 2'b00} +
                       ((r_mtvec[0] && trapIsInterrupt) ? {25'b0, trapCause, 2'b00} : 32'h0);
   assign mepcOut    = r_mepc;

endmodule

// File: doc/machine_csr_unit.md
Name: machine_csr_unit

Overview:
Parametrised successor to the machine-mode CSR file. It decodes real 12-bit CSR addresses and performs CSRRW/CSRRS/CSRRC atomically, flagging illegal accesses. It handles trap entry and mret with mstatus MIE/MPIE stacking, provides vectored mtvec, and has 64-bit cycle/instret counters with multi-retire increment. It also computes interrupt pending/cause for the control unit. Sits beside the pipeline control; reads in decode/execute, updates at writeback.

Parameters:
COUNTER_WIDTH, 64, width of mcycle/minstret (32 or 64; 32 makes the high-half addresses illegal)
RETIRE_WIDTH, 2, maximum instructions retired per cycle
VECTORED_EN, 1, 1 = mtvec.MODE may hold 1 (vectored); 0 = MODE hardwired 0

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-high reset
csrValid  in  1  CSR instruction committing this cycle
csrOp  in  2  00 read-only, 01 RW, 10 RS (set), 11 RC (clear)
csrAddr  in  12  CSR address
csrWriteData  in  32  rs1/uimm operand
csrReadData  out  32  old value of addressed CSR (combinational)
csrIllegal  out  1  access illegal (combinational)
retireCount  in  $clog2(RETIRE_WIDTH+1)  instructions retired this cycle
trapValid  in  1  take trap this cycle
trapIsInterrupt  in  1  trap is an interrupt
trapCause  in  5  exception/interrupt code
trapPC  in  32  faulting/interrupted PC
trapValue  in  32  mtval value
mretValid  in  1  mret committing
trapVector  out  32  redirect target for current trap inputs (combinational)
mepcOut  out  32  current mepc
softwareIrq/timerIrq/externalIrq  in  1 each  MSIP/MTIP/MEIP levels
irqPending  out  1  mstatus.MIE && |(mip & mie)
irqCause  out  5  11 if MEIP&MEIE, else 3 if MSIP&MSIE, else 7; 0 when none

Behaviour:
- Reset asynchronous and active-high. All CSRs are 0 except mstatus = 0x00001800 (MPP=11). Outputs follow from state: irqPending=0, csrIllegal=0 when !csrValid.
- Implemented addresses:
  - mstatus 0x300: only MIE[3], MPIE[7] writable; MPP reads 11.
  - misa 0x301: RO 0x40000100; writes ignored, not illegal.
  - mie 0x304: bits 3/7/11 writable.
  - mtvec 0x305: bit1 reads 0; bit0 WARL.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: RO reflect of the irq inputs.
  - mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82: RO shadows.
  - mhartid 0xF14 = 0.
- csrIllegal=1 when csrValid and any of: unimplemented address; csrOp!=00 with csrAddr[11:10]==11; high-half address with COUNTER_WIDTH==32. Illegal access changes no state; csrReadData=0.
- New value: RW = wdata; RS = old|wdata; RC = old&~wdata. It is masked per the WARL rules and written at the posedge. csrOp 00 never writes.
- Counters:
  - mcycle +1 every cycle; minstret +retireCount every cycle. Both wrap to 0.
  - A write to either half replaces those 32 bits and suppresses that counter's increment that cycle. The other half holds.
- Trap (trapValid):
  - mepc<=trapPC&~3; mcause<={trapIsInterrupt,26'b0,trapCause}; mtval<=trapValue.
  - MPIE<=MIE; MIE<=0.
- mret (mretValid, !trapValid): MIE<=MPIE; MPIE<=1.
- Priority in one cycle: trap > mret > CSR write. A CSR write coinciding with trap or mret is dropped; counter increments still apply.
- trapVector = {mtvec[31:2],2'b00}, plus 4*trapCause when mtvec[0]==1 and trapIsInterrupt.

Decomposition:
- Package entries:
  - csrOp_ enum.
  - CSR address localparams.
  - mstatus/mip bit-index constants.
  - mcause code constants (interrupt 3/7/11; exception 0,2,3,4,6,11).
- Sub-module csr_counter:
  - Parameter COUNTER_WIDTH; increment-amount input.
  - Low/high 32-bit write enables; wraps.
  - Instantiated for mcycle and minstret.

Test Plan:
- Reset mid-run, then release; read 0x300 -> 0x00001800; read 0xB00 on consecutive cycles -> 0,1,2.
- Write mcycle=0xFFFFFFFF, mcycleh=0 -> after 2 cycles read 0xB80 = 1, 0xB00 = 0; retireCount=2 for 3 cycles -> minstret +6.
- Set MIE (RS 0x300 with 0x8), mie=0x800, externalIrq=1 -> irqPending=1, irqCause=11. Trap at PC 0x1006 -> mepc=0x1004, mcause=0x8000000B, MIE=0, MPIE=1. mret -> MIE=1, MPIE=1.
- mtvec RW 0x00002001, trap interrupt cause 7 -> trapVector=0x0000201C. Exception cause 2 -> 0x00002000. VECTORED_EN=0 -> mtvec reads 0x00002000.
- Illegal cases: RW to 0xC00, read 0x7C0, COUNTER_WIDTH=32 read 0xB80 -> csrIllegal=1, readData 0, no state change. RS with wdata=0 on 0xF14 (op 00) -> legal, reads 0.
- Simultaneous trapValid and RW to mscratch -> mscratch unchanged, trap CSRs updated.
